// File: rtl/splitmerge_token_sched.sv
// Round-robin token scheduler for a shared 1-of-4 data/control transmit pair.
// It runs four-phase go/enable sequencing, enforces a tokens-in-flight limit and counts returned tokens.
module splitmerge_token_sched #(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_ctrl,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        tx_data,
  output logic [1:0]        cx_data,
  output logic              go,
  input  logic              Txe,
  input  logic              Cxe,
  input  logic              rx_valid,
  input  logic [1:0]        rx_data,
  output logic              busy,
  output logic [CNT_W-1:0]  tokens_sent,
  output logic [CNT_W-1:0]  tokens_rcvd,
  output logic [1:0]        last_rx,
  output logic [3:0]        out_cnt,
  output logic              timeout_err,
  output logic              rx_err,
  output logic [2:0]        dbg_state
);
  localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  OUT_LIM = 4'(MAX_OUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_NEUT = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_txe_sync, r_cxe_sync, r_rxv_sync;
  logic             r_rxv_d;
  logic             r_go;
  logic [1:0]       r_tx, r_cx, r_last;
  logic [IW-1:0]    r_win, r_rr;
  logic [15:0]      r_timer;
  logic [CNT_W-1:0] r_sent, r_rcvd;
  logic [3:0]       r_out;
  logic             r_to_err, r_rx_err;

  logic          w_txe_s, w_cxe_s, w_rx_edge, w_is_load;
  logic          w_found, w_launch, w_ack, w_neut_done, w_timeout, w_to;
  logic [IW-1:0] w_pick, w_cand;
  logic [1:0]    w_pdata, w_pctrl;

  assign w_txe_s   = r_txe_sync[1];
  assign w_cxe_s   = r_cxe_sync[1];
  assign w_rx_edge = r_rxv_sync[1] & ~r_rxv_d;
  assign w_is_load = (r_state == LOAD);
  assign w_to      = (r_timer == TO_LAST);

  // First requester at or after the rr pointer, searching upward with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = IW'((int'(r_rr) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_pdata = 2'b11;
    w_pctrl = 2'b11;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IW'(i)) begin
        w_pdata = req_data[2*i +: 2];
        w_pctrl = req_ctrl[2*i +: 2];
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_launch    = 1'b0;
    w_ack       = 1'b0;
    w_neut_done = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && (r_out < OUT_LIM) && w_txe_s && w_cxe_s) begin
          w_launch = 1'b1;
          w_next   = LOAD;
        end
      end
      LOAD: w_next = WAIT_ACK;
      WAIT_ACK: begin
        if (!w_txe_s && !w_cxe_s) begin
          w_ack  = 1'b1;
          w_next = WAIT_NEUT;
        end else if (w_to) begin
          w_timeout = 1'b1;
          w_next    = HALT;
        end
      end
      WAIT_NEUT: begin
        if (w_txe_s && w_cxe_s) begin
          w_neut_done = 1'b1;
          w_next      = IDLE;
        end else if (w_to) begin
          w_timeout = 1'b1;
          w_next    = HALT;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_txe_sync <= '0;
      r_cxe_sync <= '0;
      r_rxv_sync <= '0;
      r_rxv_d    <= 1'b0;
      r_go       <= 1'b0;
      r_tx       <= 2'b11;
      r_cx       <= 2'b11;
      r_last     <= 2'b00;
      r_win      <= '0;
      r_rr       <= '0;
      r_timer    <= '0;
      r_sent     <= '0;
      r_rcvd     <= '0;
      r_out      <= '0;
      r_to_err   <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_txe_sync <= {r_txe_sync[0], Txe};
      r_cxe_sync <= {r_cxe_sync[0], Cxe};
      r_rxv_sync <= {r_rxv_sync[0], rx_valid};
      r_rxv_d    <= r_rxv_sync[1];

      if (w_launch) begin
        r_tx  <= w_pdata;
        r_cx  <= w_pctrl;
        r_win <= w_pick;
        r_go  <= 1'b1;
      end
      if (w_ack || w_timeout) r_go <= 1'b0;
      if (w_neut_done || w_timeout) begin
        r_tx <= 2'b11;
        r_cx <= 2'b11;
      end
      if (w_timeout) r_to_err <= 1'b1;
      if (w_neut_done) begin
        r_sent <= r_sent + 1'b1;
        r_rr   <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
      end

      if (w_next != r_state) r_timer <= '0;
      else if (r_state == WAIT_ACK || r_state == WAIT_NEUT) r_timer <= r_timer + 1'b1;

      // A receive edge landing on the LOAD cycle cancels that cycle's increment.
      if (w_rx_edge) begin
        r_rcvd <= r_rcvd + 1'b1;
        r_last <= rx_data;
      end
      if (w_rx_edge && !w_is_load) begin
        if (r_out == 4'd0) r_rx_err <= 1'b1;
        else r_out <= r_out - 1'b1;
      end else if (!w_rx_edge && w_is_load) begin
        r_out <= r_out + 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_neut_done) gnt[r_win] = 1'b1;
  end

  assign go          = r_go;
  assign tx_data     = r_tx;
  assign cx_data     = r_cx;
  assign busy        = (r_state != IDLE);
  assign tokens_sent = r_sent;
  assign tokens_rcvd = r_rcvd;
  assign last_rx     = r_last;
  assign out_cnt     = r_out;
  assign timeout_err = r_to_err;
  assign rx_err      = r_rx_err;
  assign dbg_state   = r_state;
endmodule
